// File: rtl/id_ex_stage_p_if.sv
// Decode-side inputs and ID/EX outputs of the decode/execute boundary, bundled as one interface.
// The master modport drives decode inputs and observes the stage; slave is the stage itself.
interface id_ex_stage_p_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 3,
  parameter int CNT_W  = 16
);
  logic [31:0]       instr_d;
  logic [DATA_W-1:0] pc_plus4_d;
  logic              valid_d;
  logic [DATA_W-1:0] rd1_d, rd2_d, alu_out_m, result_w;
  logic [1:0]        fwd_a_d, fwd_b_d;
  logic              regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d;
  logic [ALUC_W-1:0] alucontrol_d;
  logic              branch_d, bne_d;
  logic              stall_d, stall_e, flush_e;

  logic              equal_d, pcsrc_d;
  logic [DATA_W-1:0] pc_branch_d;
  logic              regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e;
  logic [ALUC_W-1:0] alucontrol_e;
  logic [DATA_W-1:0] rd1_e, rd2_e, signimm_e;
  logic [REG_AW-1:0] rs_e, rt_e, rd_e;
  logic              valid_e;
  logic [CNT_W-1:0]  bubble_cnt;

  modport slave (
    input  instr_d, pc_plus4_d, valid_d, rd1_d, rd2_d, alu_out_m, result_w,
           fwd_a_d, fwd_b_d, regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d,
           alucontrol_d, branch_d, bne_d, stall_d, stall_e, flush_e,
    output equal_d, pcsrc_d, pc_branch_d, regwrite_e, memtoreg_e, memwrite_e,
           alusrc_e, regdst_e, alucontrol_e, rd1_e, rd2_e, signimm_e,
           rs_e, rt_e, rd_e, valid_e, bubble_cnt
  );

  modport master (
    output instr_d, pc_plus4_d, valid_d, rd1_d, rd2_d, alu_out_m, result_w,
           fwd_a_d, fwd_b_d, regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d,
           alucontrol_d, branch_d, bne_d, stall_d, stall_e, flush_e,
    input  equal_d, pcsrc_d, pc_branch_d, regwrite_e, memtoreg_e, memwrite_e,
           alusrc_e, regdst_e, alucontrol_e, rd1_e, rd2_e, signimm_e,
           rs_e, rt_e, rd_e, valid_e, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage_p.sv
// Decode/execute boundary of the 5-stage MIPS pipeline: branch resolution in decode with
// forwarded compare, branch target, and the ID/EX register with stall, flush and bubble count.
module id_ex_stage_p #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 3,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             clr,
  id_ex_stage_p_if.slave  bus
);
  logic [DATA_W-1:0] w_signimm, w_op_a, w_op_b;
  logic              w_equal;
  logic              w_unused_opcode;

  logic              r_regwrite, r_memtoreg, r_memwrite, r_alusrc, r_regdst, r_valid;
  logic [ALUC_W-1:0] r_alucontrol;
  logic [DATA_W-1:0] r_rd1, r_rd2, r_signimm;
  logic [REG_AW-1:0] r_rs, r_rt, r_rd;
  logic [CNT_W-1:0]  r_bubble_cnt;

  assign w_unused_opcode = ^bus.instr_d[31:26];
  assign w_signimm       = DATA_W'($signed(bus.instr_d[15:0]));

  // Select 11 deliberately falls back to the register file.
  always_comb begin
    w_op_a = bus.rd1_d;
    case (bus.fwd_a_d)
      2'b01:   w_op_a = bus.alu_out_m;
      2'b10:   w_op_a = bus.result_w;
      default: w_op_a = bus.rd1_d;
    endcase
    w_op_b = bus.rd2_d;
    case (bus.fwd_b_d)
      2'b01:   w_op_b = bus.alu_out_m;
      2'b10:   w_op_b = bus.result_w;
      default: w_op_b = bus.rd2_d;
    endcase
  end

  assign w_equal         = (w_op_a == w_op_b);
  assign bus.equal_d     = w_equal;
  assign bus.pcsrc_d     = bus.branch_d & bus.valid_d & ~bus.stall_d &
                           (bus.bne_d ? ~w_equal : w_equal);
  assign bus.pc_branch_d = bus.pc_plus4_d + (w_signimm << 2);

  // Priority: clr, then flush (wins over stall), then stall hold, then load.
  always_ff @(posedge clk) begin
    if (clr || bus.flush_e) begin
      r_regwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_memwrite   <= 1'b0;
      r_alusrc     <= 1'b0;
      r_regdst     <= 1'b0;
      r_alucontrol <= '0;
      r_valid      <= 1'b0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_signimm    <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      if (clr)
        r_bubble_cnt <= '0;
      else if (r_bubble_cnt != {CNT_W{1'b1}})
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end else if (!bus.stall_e) begin
      r_regwrite   <= bus.valid_d & bus.regwrite_d;
      r_memtoreg   <= bus.valid_d & bus.memtoreg_d;
      r_memwrite   <= bus.valid_d & bus.memwrite_d;
      r_alusrc     <= bus.valid_d & bus.alusrc_d;
      r_regdst     <= bus.valid_d & bus.regdst_d;
      r_alucontrol <= bus.valid_d ? bus.alucontrol_d : '0;
      r_valid      <= bus.valid_d;
      r_rd1        <= bus.rd1_d;
      r_rd2        <= bus.rd2_d;
      r_signimm    <= w_signimm;
      r_rs         <= bus.instr_d[21 +: REG_AW];
      r_rt         <= bus.instr_d[16 +: REG_AW];
      r_rd         <= bus.instr_d[11 +: REG_AW];
    end
  end

  assign bus.regwrite_e   = r_regwrite;
  assign bus.memtoreg_e   = r_memtoreg;
  assign bus.memwrite_e   = r_memwrite;
  assign bus.alusrc_e     = r_alusrc;
  assign bus.regdst_e     = r_regdst;
  assign bus.alucontrol_e = r_alucontrol;
  assign bus.valid_e      = r_valid;
  assign bus.rd1_e        = r_rd1;
  assign bus.rd2_e        = r_rd2;
  assign bus.signimm_e    = r_signimm;
  assign bus.rs_e         = r_rs;
  assign bus.rt_e         = r_rt;
  assign bus.rd_e         = r_rd;
  assign bus.bubble_cnt   = r_bubble_cnt;
endmodule

// File: tb/tb_id_ex_stage_p.sv
// Directed bench for id_ex_stage_p: reset, branch resolution, forwarded compare,
// stall/flush priority, invalid slot and bubble-counter saturation (second instance, CNT_W=2).
module tb_id_ex_stage_p;
  logic clk;
  logic clr;
  logic clr2;
  int   n_total;
  int   n_pass;

  id_ex_stage_p_if            b();
  id_ex_stage_p_if #(.CNT_W(2)) b2();

  id_ex_stage_p dut (
    .clk (clk),
    .clr (clr),
    .bus (b)
  );

  id_ex_stage_p #(.CNT_W(2)) dut2 (
    .clk (clk),
    .clr (clr2),
    .bus (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    b.instr_d = '0; b.pc_plus4_d = '0; b.valid_d = 1'b0;
    b.rd1_d = '0; b.rd2_d = '0; b.alu_out_m = '0; b.result_w = '0;
    b.fwd_a_d = 2'b00; b.fwd_b_d = 2'b00;
    b.regwrite_d = 1'b0; b.memtoreg_d = 1'b0; b.memwrite_d = 1'b0;
    b.alusrc_d = 1'b0; b.regdst_d = 1'b0; b.alucontrol_d = '0;
    b.branch_d = 1'b0; b.bne_d = 1'b0; b.stall_d = 1'b0;
    b.stall_e = 1'b0; b.flush_e = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    clear_inputs();
    b2.instr_d = '0; b2.pc_plus4_d = '0; b2.valid_d = 1'b0;
    b2.rd1_d = '0; b2.rd2_d = '0; b2.alu_out_m = '0; b2.result_w = '0;
    b2.fwd_a_d = 2'b00; b2.fwd_b_d = 2'b00;
    b2.regwrite_d = 1'b0; b2.memtoreg_d = 1'b0; b2.memwrite_d = 1'b0;
    b2.alusrc_d = 1'b0; b2.regdst_d = 1'b0; b2.alucontrol_d = '0;
    b2.branch_d = 1'b0; b2.bne_d = 1'b0; b2.stall_d = 1'b0;
    b2.stall_e = 1'b0; b2.flush_e = 1'b0;
    clr2 = 1'b1;

    // Reset with busy inputs, including a flush request that clr must override.
    clr = 1'b1;
    b.instr_d = 32'hAC85_1234; b.valid_d = 1'b1; b.regwrite_d = 1'b1;
    b.memwrite_d = 1'b1; b.alucontrol_d = 3'b110; b.rd1_d = 32'hDEAD_BEEF;
    b.rd2_d = 32'h1234_5678; b.flush_e = 1'b1;
    tick();
    tick();
    chk("rst_regwrite_e", b.regwrite_e, 0);
    chk("rst_memwrite_e", b.memwrite_e, 0);
    chk("rst_alucontrol_e", b.alucontrol_e, 0);
    chk("rst_rd1_e", b.rd1_e, 0);
    chk("rst_signimm_e", b.signimm_e, 0);
    chk("rst_rs_e", b.rs_e, 0);
    chk("rst_valid_e", b.valid_e, 0);
    chk("rst_bubble_cnt", b.bubble_cnt, 0);

    // add $3,$1,$2
    clr = 1'b0;
    clear_inputs();
    b.instr_d = 32'h0022_1820; b.valid_d = 1'b1; b.regwrite_d = 1'b1; b.regdst_d = 1'b1;
    b.rd1_d = 32'd11; b.rd2_d = 32'd22; b.alucontrol_d = 3'b010;
    tick();
    chk("add_rs_e", b.rs_e, 1);
    chk("add_rt_e", b.rt_e, 2);
    chk("add_rd_e", b.rd_e, 3);
    chk("add_regwrite_e", b.regwrite_e, 1);
    chk("add_regdst_e", b.regdst_e, 1);
    chk("add_valid_e", b.valid_e, 1);
    chk("add_rd1_e", b.rd1_e, 11);
    chk("add_rd2_e", b.rd2_e, 22);
    chk("add_signimm_e", b.signimm_e, 32'h0000_1820);
    chk("add_bubble_cnt", b.bubble_cnt, 0);

    // beq with imm -1 at pc+4 0x100
    clear_inputs();
    b.instr_d = 32'h1000_FFFF; b.pc_plus4_d = 32'h100; b.valid_d = 1'b1;
    b.rd1_d = 32'd7; b.rd2_d = 32'd7; b.branch_d = 1'b1;
    #1;
    chk("beq_pc_branch_d", b.pc_branch_d, 32'h0000_00FC);
    chk("beq_equal_d", b.equal_d, 1);
    chk("beq_pcsrc_d", b.pcsrc_d, 1);
    b.bne_d = 1'b1;
    #1;
    chk("bne_pcsrc_d", b.pcsrc_d, 0);
    b.bne_d = 1'b0; b.stall_d = 1'b1;
    #1;
    chk("stall_d_pcsrc_d", b.pcsrc_d, 0);
    b.stall_d = 1'b0; b.valid_d = 1'b0;
    #1;
    chk("invalid_pcsrc_d", b.pcsrc_d, 0);
    b.valid_d = 1'b1; b.rd2_d = 32'd8; b.bne_d = 1'b1;
    #1;
    chk("bne_taken_pcsrc_d", b.pcsrc_d, 1);
    b.pc_plus4_d = 32'h0;
    #1;
    chk("wrap_pc_branch_d", b.pc_branch_d, 32'hFFFF_FFFC);
    b.instr_d = 32'h1000_0010; b.pc_plus4_d = 32'h100;
    #1;
    chk("fwd_pc_branch_d", b.pc_branch_d, 32'h0000_0140);

    // Forwarded compare
    b.rd1_d = 32'd5; b.alu_out_m = 32'd9; b.rd2_d = 32'd9; b.fwd_a_d = 2'b01; b.fwd_b_d = 2'b00;
    #1;
    chk("fwd_a01_equal_d", b.equal_d, 1);
    b.fwd_a_d = 2'b10; b.result_w = 32'd4;
    #1;
    chk("fwd_a10_equal_d", b.equal_d, 0);
    b.fwd_a_d = 2'b11;
    #1;
    chk("fwd_a11_equal_d", b.equal_d, 0);
    b.fwd_a_d = 2'b00; b.fwd_b_d = 2'b10; b.result_w = 32'd5;
    #1;
    chk("fwd_b10_equal_d", b.equal_d, 1);
    b.fwd_a_d = 2'b01; b.fwd_b_d = 2'b01;
    #1;
    chk("fwd_b01_equal_d", b.equal_d, 1);

    // lw $5,8($2), then hold for three cycles with changing inputs
    clear_inputs();
    b.instr_d = 32'h8C45_0008; b.valid_d = 1'b1; b.memtoreg_d = 1'b1; b.regwrite_d = 1'b1;
    b.alusrc_d = 1'b1; b.alucontrol_d = 3'b010; b.rd1_d = 32'h40; b.rd2_d = 32'h77;
    tick();
    chk("lw_memtoreg_e", b.memtoreg_e, 1);
    chk("lw_alusrc_e", b.alusrc_e, 1);
    chk("lw_rt_e", b.rt_e, 5);
    chk("lw_signimm_e", b.signimm_e, 8);
    chk("lw_alucontrol_e", b.alucontrol_e, 3'b010);
    b.stall_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b.instr_d = 32'h0022_1820 + i; b.memtoreg_d = 1'b0; b.alusrc_d = 1'b0;
      b.regdst_d = 1'b1; b.rd1_d = 32'h99 + i; b.alucontrol_d = 3'b110;
      tick();
      chk("hold_memtoreg_e", b.memtoreg_e, 1);
      chk("hold_rd1_e", b.rd1_e, 32'h40);
      chk("hold_rt_e", b.rt_e, 5);
      chk("hold_regdst_e", b.regdst_e, 0);
      chk("hold_bubble_cnt", b.bubble_cnt, 0);
    end
    b.flush_e = 1'b1;
    tick();
    chk("flush_valid_e", b.valid_e, 0);
    chk("flush_memtoreg_e", b.memtoreg_e, 0);
    chk("flush_regwrite_e", b.regwrite_e, 0);
    chk("flush_rd1_e", b.rd1_e, 0);
    chk("flush_rt_e", b.rt_e, 0);
    chk("flush_bubble_cnt", b.bubble_cnt, 1);

    // Invalid slot carrying a store
    clear_inputs();
    b.instr_d = 32'hAC85_0004; b.memwrite_d = 1'b1; b.regwrite_d = 1'b1; b.valid_d = 1'b0;
    tick();
    chk("inv_memwrite_e", b.memwrite_e, 0);
    chk("inv_regwrite_e", b.regwrite_e, 0);
    chk("inv_valid_e", b.valid_e, 0);
    chk("inv_bubble_cnt", b.bubble_cnt, 1);

    // clr during a stall restarts the counter
    b.stall_e = 1'b1; clr = 1'b1;
    tick();
    chk("clr_stall_bubble_cnt", b.bubble_cnt, 0);
    clr = 1'b0; b.stall_e = 1'b0;

    // Saturating counter on the CNT_W=2 instance
    tick();
    clr2 = 1'b0;
    b2.flush_e = 1'b1; b2.valid_d = 1'b1; b2.regwrite_d = 1'b1;
    tick(); chk("sat_cnt_1", b2.bubble_cnt, 1);
    tick(); chk("sat_cnt_2", b2.bubble_cnt, 2);
    tick(); chk("sat_cnt_3", b2.bubble_cnt, 3);
    tick(); chk("sat_cnt_4", b2.bubble_cnt, 3);
    tick(); chk("sat_cnt_5", b2.bubble_cnt, 3);
    chk("sat_valid_e", b2.valid_e, 0);
    clr2 = 1'b1;
    tick();
    chk("sat_clr_cnt", b2.bubble_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
